// File: rtl/fifo_rd_ctrl.sv
// Read-side controller for a registered-output FIFO. It issues rd pulses only
// when the FIFO has data and the 2-entry skid buffer can absorb the returning
// word. It streams a programmed number of words on valid/ready, then pulses
// done.
module fifo_rd_ctrl #(
  parameter int bw    = 4,
  parameter int simd  = 1,
  parameter int len_w = 8
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 start,
  input  logic [len_w-1:0]     len,
  input  logic                 fifo_empty,
  output logic                 fifo_rd,
  input  logic [simd*bw-1:0]   fifo_data,
  output logic [simd*bw-1:0]   out_data,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic                 busy,
  output logic                 done,
  output logic [len_w-1:0]     word_cnt
);

  localparam int DW = simd * bw;

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DRAIN,
    DONE
  } state_t;

  state_t           state;
  logic [len_w-1:0] len_q;
  logic [len_w-1:0] issued;
  logic             inflight;
  logic [1:0]       occ;
  logic [DW-1:0]    buf0;
  logic [DW-1:0]    buf1;
  logic             pop;
  logic [2:0]       room_need;

  assign out_valid = (occ != 2'd0);
  assign out_data  = buf0;

  // Read gating: a new read is legal only if the buffer plus the word already
  // in flight, less this cycle's pop, leaves room for one more entry.
  always_comb begin
    pop       = (occ != 2'd0) & out_ready;
    room_need = {1'b0, occ} + {2'b00, inflight} - {2'b00, pop};
    fifo_rd   = !reset && (state == RUN) && !fifo_empty &&
                (issued < len_q) && (room_need <= 3'd1);
  end

  // Transfer FSM with counters; busy and done are registered with the state.
  always_ff @(posedge clk) begin
    if (reset) begin
      state    <= IDLE;
      len_q    <= '0;
      issued   <= '0;
      word_cnt <= '0;
      busy     <= 1'b0;
      done     <= 1'b0;
    end else begin
      done <= 1'b0;
      if (pop) begin
        word_cnt <= word_cnt + 1'b1;
      end
      if (fifo_rd) begin
        issued <= issued + 1'b1;
      end
      case (state)
        IDLE: begin
          if (start) begin
            len_q    <= len;
            issued   <= '0;
            word_cnt <= '0;
            if (len == '0) begin
              state <= DONE;
              done  <= 1'b1;
            end else begin
              state <= RUN;
              busy  <= 1'b1;
            end
          end
        end
        RUN: begin
          if (fifo_rd && (issued + 1'b1 == len_q)) begin
            state <= DRAIN;
          end
        end
        DRAIN: begin
          if (pop && (word_cnt + 1'b1 == len_q)) begin
            state <= DONE;
            done  <= 1'b1;
            busy  <= 1'b0;
          end
        end
        DONE: begin
          state <= IDLE;
        end
        default: begin
          state <= IDLE;
          busy  <= 1'b0;
        end
      endcase
    end
  end

  // Skid buffer: buf0 is the head. The word read last cycle is captured from
  // fifo_data this cycle, while the head drains on pop.
  always_ff @(posedge clk) begin
    if (reset) begin
      inflight <= 1'b0;
      occ      <= 2'd0;
      buf0     <= '0;
      buf1     <= '0;
    end else begin
      inflight <= fifo_rd;
      case ({inflight, pop})
        2'b10: begin
          if (occ == 2'd0) begin
            buf0 <= fifo_data;
          end else begin
            buf1 <= fifo_data;
          end
          occ <= occ + 1'b1;
        end
        2'b01: begin
          if (occ == 2'd2) begin
            buf0 <= buf1;
          end
          occ <= occ - 1'b1;
        end
        2'b11: begin
          if (occ == 2'd1) begin
            buf0 <= fifo_data;
          end else begin
            buf0 <= buf1;
            buf1 <= fifo_data;
          end
        end
        default: begin
        end
      endcase
    end
  end

  // The read gating makes overflow impossible; flag it if it ever happens.
  overflow_a: assert property (@(posedge clk) disable iff (reset)
    !(inflight && !pop && (occ == 2'd2)));
  occ_range_a: assert property (@(posedge clk) disable iff (reset)
    occ != 2'd3);

endmodule

// File: tb/tb_fifo_rd_ctrl.sv
// Directed bench for fifo_rd_ctrl. It includes a behavioural registered-output
// FIFO and an event log sampled on the falling edge.
module tb_fifo_rd_ctrl;

  localparam int BW    = 4;
  localparam int SIMD  = 1;
  localparam int LEN_W = 8;
  localparam int W     = BW * SIMD;

  logic             clk = 1'b0;
  logic             reset;
  logic             start;
  logic [LEN_W-1:0] len;
  logic             fifo_empty;
  logic             fifo_rd;
  logic [W-1:0]     fifo_data = '0;
  logic [W-1:0]     out_data;
  logic             out_valid;
  logic             out_ready;
  logic             busy;
  logic             done;
  logic [LEN_W-1:0] word_cnt;

  int total = 0;
  int bad   = 0;
  int cyc   = 0;
  int s;

  logic [W-1:0] fq[$];
  int n_push = 0;
  int n_pop  = 0;

  int           rd_cyc[$];
  int           pop_cyc[$];
  int           done_cyc[$];
  logic [W-1:0] pop_data[$];
  int           rd_empty_err = 0;
  int           stab_err     = 0;
  int           busy_n       = 0;
  int           busy_base;
  logic         prev_stall   = 1'b0;
  logic [W-1:0] prev_data    = '0;

  always #5 clk = ~clk;

  assign fifo_empty = (n_push == n_pop);

  fifo_rd_ctrl #(
    .bw   (BW),
    .simd (SIMD),
    .len_w(LEN_W)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .start     (start),
    .len       (len),
    .fifo_empty(fifo_empty),
    .fifo_rd   (fifo_rd),
    .fifo_data (fifo_data),
    .out_data  (out_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .busy      (busy),
    .done      (done),
    .word_cnt  (word_cnt)
  );

  always @(posedge clk) cyc <= cyc + 1;

  // Registered-output FIFO: the out register loads on rd only when not empty.
  always @(posedge clk) begin
    if (fifo_rd && fq.size() > 0) begin
      fifo_data <= fq.pop_front();
      n_pop     <= n_pop + 1;
    end
  end

  // Event log, sampled mid-cycle.
  always @(negedge clk) begin
    if (fifo_rd && fifo_empty) rd_empty_err++;
    if (fifo_rd) rd_cyc.push_back(cyc);
    if (!reset && out_valid && out_ready) begin
      pop_data.push_back(out_data);
      pop_cyc.push_back(cyc);
    end
    if (done) done_cyc.push_back(cyc);
    if (busy) busy_n++;
    if (!reset && prev_stall && (!out_valid || out_data != prev_data)) stab_err++;
    prev_stall = !reset && out_valid && !out_ready;
    prev_data  = out_data;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=0x%0h expected=0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic run(input int n);
    repeat (n) tick();
  endtask

  task automatic push(input logic [W-1:0] v);
    fq.push_back(v);
    n_push++;
  endtask

  task automatic clear_logs();
    rd_cyc.delete();
    pop_cyc.delete();
    done_cyc.delete();
    pop_data.delete();
    busy_base = busy_n;
  endtask

  function automatic int first_or(input int q[$]);
    return (q.size() > 0) ? q[0] : -1000;
  endfunction

  function automatic int last_or(input int q[$]);
    return (q.size() > 0) ? q[q.size()-1] : -1000;
  endfunction

  function automatic logic [31:0] pack(input logic [W-1:0] q[$]);
    logic [31:0] pk = '0;
    foreach (q[i]) pk = (pk << W) | 32'(q[i]);
    return pk;
  endfunction

  task automatic begin_xfer(input logic [LEN_W-1:0] n);
    clear_logs();
    s     = cyc;
    start = 1'b1;
    len   = n;
    tick();
    start = 1'b0;
  endtask

  initial begin
    int early;
    reset     = 1'b1;
    start     = 1'b0;
    len       = '0;
    out_ready = 1'b1;
    run(2);
    @(negedge clk);
    check("rst_valid", 32'(out_valid), 0);
    check("rst_busy", 32'(busy), 0);
    check("rst_done", 32'(done), 0);
    check("rst_data", 32'(out_data), 0);
    check("rst_cnt", 32'(word_cnt), 0);
    check("rst_rd", 32'(fifo_rd), 0);
    tick();
    reset = 1'b0;
    run(2);

    // Basic transfer of five preloaded words.
    for (int i = 1; i <= 5; i++) push(W'(i));
    begin_xfer(8'd5);
    run(20);
    check("t1_rd_n", rd_cyc.size(), 5);
    check("t1_rd_first", first_or(rd_cyc) - s, 1);
    check("t1_rd_last", last_or(rd_cyc) - s, 5);
    check("t1_pop_n", pop_data.size(), 5);
    check("t1_data", pack(pop_data), 32'h12345);
    check("t1_pop_first", first_or(pop_cyc) - s, 3);
    check("t1_pop_last", last_or(pop_cyc) - s, 7);
    check("t1_done_n", done_cyc.size(), 1);
    check("t1_done_at", first_or(done_cyc) - s, 8);
    check("t1_cnt", 32'(word_cnt), 5);
    check("t1_busy_n", busy_n - busy_base, 7);

    // Backpressure: downstream stalls through cycle s+6.
    for (int i = 10; i <= 13; i++) push(W'(i));
    out_ready = 1'b0;
    begin_xfer(8'd4);
    run(4);
    @(negedge clk);
    check("t2_hold_valid", 32'(out_valid), 1);
    check("t2_hold_data", 32'(out_data), 32'hA);
    run(2);
    out_ready = 1'b1;
    run(15);
    early = 0;
    foreach (rd_cyc[i]) if (rd_cyc[i] < s + 7) early++;
    check("t2_rd_pre_stall", early, 2);
    check("t2_rd_n", rd_cyc.size(), 4);
    check("t2_data", pack(pop_data), 32'hABCD);
    check("t2_pop_first", first_or(pop_cyc) - s, 7);
    check("t2_done_at", first_or(done_cyc) - s, 11);
    check("t2_done_n", done_cyc.size(), 1);
    check("t2_cnt", 32'(word_cnt), 4);

    // Starved FIFO: one word every four cycles.
    push(4'h7);
    begin_xfer(8'd3);
    run(3);
    push(4'h8);
    run(4);
    push(4'h9);
    run(15);
    check("t3_data", pack(pop_data), 32'h789);
    check("t3_rd_n", rd_cyc.size(), 3);
    check("t3_done_after_pop", first_or(done_cyc) - last_or(pop_cyc), 1);
    check("t3_done_at", first_or(done_cyc) - s, 11);
    check("t3_done_n", done_cyc.size(), 1);

    // Zero-length transfer.
    begin_xfer(8'd0);
    run(5);
    check("t4_done_at", first_or(done_cyc) - s, 1);
    check("t4_done_n", done_cyc.size(), 1);
    check("t4_rd_n", rd_cyc.size(), 0);
    check("t4_busy_n", busy_n - busy_base, 0);
    check("t4_cnt", 32'(word_cnt), 0);

    // Reset after the third read; the word still in flight must vanish.
    for (int i = 1; i <= 6; i++) push(W'(i));
    begin_xfer(8'd6);
    run(3);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    @(negedge clk);
    check("t5_valid", 32'(out_valid), 0);
    check("t5_busy", 32'(busy), 0);
    check("t5_rd", 32'(fifo_rd), 0);
    fq.delete();
    n_push = n_pop;
    run(4);
    check("t5_rd_n", rd_cyc.size(), 3);
    check("t5_emitted", pack(pop_data), 32'h1);
    push(4'h3);
    push(4'hC);
    begin_xfer(8'd2);
    run(10);
    check("t5_re_data", pack(pop_data), 32'h3C);
    check("t5_re_done_n", done_cyc.size(), 1);
    check("t5_re_cnt", 32'(word_cnt), 2);

    // A start during RUN must not restart or extend the transfer.
    push(4'h1);
    push(4'h2);
    push(4'h3);
    begin_xfer(8'd3);
    tick();
    start = 1'b1;
    len   = 8'd9;
    tick();
    start = 1'b0;
    run(15);
    check("t6_data", pack(pop_data), 32'h123);
    check("t6_rd_n", rd_cyc.size(), 3);
    check("t6_done_n", done_cyc.size(), 1);
    check("t6_cnt", 32'(word_cnt), 3);

    check("rd_on_empty", rd_empty_err, 0);
    check("stall_stable", stab_err, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/fifo_rd_ctrl.md
Name: fifo_rd_ctrl

Overview:
- Read-side controller that drains one registered-output FIFO: the FIFO's out register updates on the rd_clk edge where rd=1, and its pointer advances only if not empty.
- Issues rd pulses only when legal and captures the returned words into a 2-entry skid buffer.
- Presents the words on a valid/ready stream for a programmed transfer length, then pulses done.
- Sits between the output FIFO and the SRAM/psum write path; runs on the FIFO's read clock.

Parameters:
- bw, 4: element width; matches the FIFO bw.
- simd, 1: elements per word; data width is simd*bw.
- len_w, 8: width of the transfer-length and count fields.

Ports:
- clk  in  1  read-side clock; drives the FIFO rd_clk.
- reset  in  1  synchronous, active-high.
- start  in  1  one-cycle request to begin a transfer; accepted only in IDLE.
- len  in  len_w  words to transfer; sampled on an accepted start.
- fifo_empty  in  1  FIFO o_empty.
- fifo_rd  out  1  FIFO rd; combinational.
- fifo_data  in  simd*bw  FIFO out.
- out_data  out  simd*bw  head of the skid buffer.
- out_valid  out  1  skid buffer non-empty.
- out_ready  in  1  downstream accept.
- busy  out  1  state is RUN or DRAIN.
- done  out  1  one-cycle pulse when the transfer completes.
- word_cnt  out  len_w  words delivered in the current or last transfer.

Behaviour:
- Clock and reset: one clock (clk); reset is synchronous and active-high.
- Reset values:
  - state=IDLE; issued=0; word_cnt=0; inflight=0; occ=0.
  - out_valid=0, busy=0, done=0, out_data=0.
  - fifo_rd=0 combinationally while reset=1 or state=IDLE.
- pop = out_valid & out_ready.
- fifo_rd = (state==RUN) & !fifo_empty & (issued<len_q) & (occ + inflight - pop <= 1).
  - Never assert rd on empty: the FIFO would overwrite its out register with a stale word.
- inflight <= fifo_rd (registered). fifo_data is valid in the cycle after fifo_rd.
  - When inflight=1, fifo_data is written into the skid buffer at the end of that cycle.
- Latency: fifo_rd in cycle N gives out_valid in cycle N+2 (empty buffer).
- Throughput: sustained 1 word/cycle while out_ready=1 and the FIFO is non-empty.
- Skid buffer:
  - 2 entries, FIFO order; occ ranges 0..2.
  - Push and pop in the same cycle are both honoured.
  - A push when occ=2 with no pop is impossible by construction; flag it as an assertion.
- Stream rules:
  - out_data and out_valid stay stable while out_valid=1 and out_ready=0.
  - out_data holds its last value when occ=0.
- issued increments on each fifo_rd; word_cnt increments on each pop.
- FSM:
  - IDLE: start=1 latches len_q=len, clears issued and word_cnt, moves to RUN. If len=0, go directly to DONE.
  - RUN: issue reads. When issued==len_q after this cycle's increment, go to DRAIN.
  - DRAIN: no reads. When word_cnt==len_q (last pop this cycle), go to DONE.
  - DONE: done=1 for this single cycle, then IDLE. word_cnt holds until the next start.
- Start outside IDLE is ignored.
- Arithmetic:
  - issued and word_cnt are len_w bits; maximum transfer is 2^len_w-1 words.
  - Comparisons are unsigned and exact; there is no wrap within a transfer.
- Reset mid-transfer:
  - Returns to IDLE next edge; buffer is discarded; inflight is cleared.
  - A word returning in the following cycle is dropped.
  - The FIFO is reset by its own reset.
- FIFO goes empty mid-RUN: stall reads with no loss; resume when fifo_empty=0.
- out_ready held low: reads stop after at most 2 words are buffered or in flight. No overflow.

Test Plan:
- Basic transfer: FIFO preloaded 0x1..0x5, len=5, out_ready=1.
  - Required: fifo_rd high 5 consecutive cycles from the cycle after start.
  - Required: out_valid first 2 cycles after the first rd; outputs 1,2,3,4,5 back-to-back.
  - Required: done pulse 1 cycle after the last pop; word_cnt=5.
- Backpressure: len=4, FIFO full with 0xA..0xD, out_ready=0 for 6 cycles then 1.
  - Required: exactly 2 rd pulses before the stall.
  - Required: out_data holds 0xA stable; then A,B,C,D in order; done.
- Starved FIFO: len=3, FIFO writes 1 word every 4 cycles.
  - Required: fifo_rd never asserted while fifo_empty=1; outputs in order; done after the 3rd pop.
- len=0: start with len=0 -> done pulse in the next cycle, no fifo_rd, busy stays 0, word_cnt=0.
- Reset mid-op: len=6, assert reset after the 3rd rd.
  - Required: out_valid=0, busy=0, fifo_rd=0 next cycle; the in-flight word is not emitted.
  - Required: a new start with len=2 works normally.
- Ignored start: start pulsed during RUN with len=9 -> the transfer completes with the original len; no second done.
